// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// State encodings are fixed 3-bit values so they can be matched in waveforms and debug taps.
package mem_loader_pkg;

  typedef enum logic [2:0] {
    LDR_IDLE  = 3'd0,
    LDR_LEN   = 3'd1,
    LDR_LOAD  = 3'd2,
    LDR_CHECK = 3'd3,
    LDR_DONE  = 3'd4,
    LDR_ERR   = 3'd5
  } ldr_state_t;

  localparam logic [7:0] LDR_DEFAULT_BASE = 8'h00;

  // A length byte of zero encodes a full 256-byte image.
  function automatic logic [8:0] ldr_len(input logic [7:0] b);
    return (b == 8'h00) ? 9'd256 : {1'b0, b};
  endfunction

endpackage

// File: rtl/mem_loader.sv
// Boot loader: frames a length-prefixed byte stream into single-byte memory writes
// and holds the CPU until the image is in. Define LOADER_CHECKSUM_EN for a trailing checksum byte.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR     = LDR_DEFAULT_BASE,
  parameter bit         HOLD_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       mem_write,
  output logic       cpu_hold,
  output logic       done,
  output logic       error,
  output logic [8:0] byte_count
);

  ldr_state_t state, nstate;
  logic [8:0] len;
  logic       begin_load;
  logic       load_xfer;
  logic       enter_done;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_final;
  logic       enter_err;
  assign sum_final = sum + rx_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= LDR_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate     = state;
    rx_ready   = 1'b0;
    begin_load = 1'b0;
    load_xfer  = 1'b0;
    case (state)
      LDR_IDLE, LDR_DONE, LDR_ERR: begin
        if (start) begin
          nstate     = LDR_LEN;
          begin_load = 1'b1;
        end
      end
      LDR_LEN: begin
        rx_ready = 1'b1;
        if (rx_valid) nstate = LDR_LOAD;
      end
      LDR_LOAD: begin
        rx_ready  = 1'b1;
        load_xfer = rx_valid;
        if (rx_valid && (byte_count + 9'd1 == len)) begin
`ifdef LOADER_CHECKSUM_EN
          nstate = LDR_CHECK;
`else
          nstate = LDR_DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      LDR_CHECK: begin
        rx_ready = 1'b1;
        if (rx_valid) nstate = (sum_final == 8'h00) ? LDR_DONE : LDR_ERR;
      end
`endif
      default: nstate = LDR_IDLE;
    endcase
  end

  assign enter_done = (nstate == LDR_DONE) && (state != LDR_DONE);

  // mem_addr advances after each write cycle, so back-to-back bytes land on consecutive addresses.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr   <= BASE_ADDR;
      mem_data   <= 8'h00;
      mem_write  <= 1'b0;
      cpu_hold   <= HOLD_ON_RESET;
      done       <= 1'b0;
      byte_count <= 9'd0;
      len        <= 9'd0;
    end else begin
      mem_write <= 1'b0;
      if (mem_write) mem_addr <= mem_addr + 8'd1;
      if (begin_load) begin
        cpu_hold   <= 1'b1;
        done       <= 1'b0;
        byte_count <= 9'd0;
        mem_addr   <= BASE_ADDR;
      end
      if (state == LDR_LEN && rx_valid) len <= ldr_len(rx_data);
      if (load_xfer) begin
        mem_data   <= rx_data;
        mem_write  <= 1'b1;
        byte_count <= byte_count + 9'd1;
      end
      if (enter_done) begin
        done     <= 1'b1;
        cpu_hold <= 1'b0;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  assign enter_err = (nstate == LDR_ERR) && (state != LDR_ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= 8'h00;
      error <= 1'b0;
    end else begin
      if (begin_load) begin
        sum   <= 8'h00;
        error <= 1'b0;
      end
      if (load_xfer) sum   <= sum + rx_data;
      if (enter_err) error <= 1'b1;
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: two instances (base 00 / hold-on-reset, base FE / no hold).
module tb_mem_loader;

  logic       clk = 1'b0;
  logic       rst, start, rx_valid;
  logic [7:0] rx_data;

  logic       rx_ready, mem_write, cpu_hold, done, error;
  logic [7:0] mem_addr, mem_data;
  logic [8:0] byte_count;

  logic       rx_ready2, mem_write2, cpu_hold2, done2, error2;
  logic [7:0] mem_addr2, mem_data2;
  logic [8:0] byte_count2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] wa[$];
  logic [7:0] wd[$];
  int         wc[$];
  logic [7:0] wa2[$];

  mem_loader dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
    .cpu_hold(cpu_hold), .done(done), .error(error), .byte_count(byte_count)
  );

  mem_loader #(.BASE_ADDR(8'hFE), .HOLD_ON_RESET(1'b0)) dut2 (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready2), .mem_addr(mem_addr2), .mem_data(mem_data2), .mem_write(mem_write2),
    .cpu_hold(cpu_hold2), .done(done2), .error(error2), .byte_count(byte_count2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_write) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_data);
      wc.push_back(cyc);
    end
    if (mem_write2) wa2.push_back(mem_addr2);
  end

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete(); wa2.delete();
  endtask

  task automatic send(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout rx_ready got=0 need=1 byte=%02h", b);
      rx_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL rst_hold got=%0b need=1", cpu_hold); end
    total++; if (cpu_hold2 !== 1'b0) begin bad++; $display("FAIL rst_hold2 got=%0b need=0", cpu_hold2); end
    total++; if (mem_addr !== 8'h00 || mem_addr2 !== 8'hFE) begin bad++; $display("FAIL rst_addr got=%02h/%02h need=00/fe", mem_addr, mem_addr2); end
    total++; if ({done, error, mem_write, rx_ready} !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%04b need=0000", {done, error, mem_write, rx_ready}); end
    total++; if (byte_count !== 9'd0 || mem_data !== 8'h00) begin bad++; $display("FAIL rst_count got=%0d/%02h need=0/00", byte_count, mem_data); end
  endtask

  task automatic test_basic();
    logic [7:0] ed[3];
    ed[0] = 8'hAA; ed[1] = 8'hBB; ed[2] = 8'hCC;
    clear_log();
    pulse_start();
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%0b need=1", rx_ready); end
    send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC);
`ifdef LOADER_CHECKSUM_EN
    send(8'hCF);  // AA+BB+CC = 0x231 -> 0x31; 0x31 + 0xCF wraps to 0
`endif
    idle(2);
    total++; if (wa.size() != 3) begin bad++; $display("FAIL basic_nwrites got=%0d need=3", wa.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (wa[i] !== 8'(i) || wd[i] !== ed[i]) begin
          bad++; $display("FAIL basic_write%0d got=%02h:%02h need=%02h:%02h", i, wa[i], wd[i], 8'(i), ed[i]);
        end
      end
      total++; if (wc[1] - wc[0] != 1 || wc[2] - wc[1] != 1) begin bad++; $display("FAIL basic_b2b got gaps %0d,%0d need 1,1", wc[1]-wc[0], wc[2]-wc[1]); end
    end
    total++; if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL basic_flags got done=%0b hold=%0b err=%0b need 1,0,0", done, cpu_hold, error); end
    total++; if (byte_count !== 9'd3) begin bad++; $display("FAIL basic_count got=%0d need=3", byte_count); end
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_done got=%0b need=0", rx_ready); end
  endtask

  task automatic test_wrap();
    logic [7:0] ea[4];
    ea[0] = 8'hFE; ea[1] = 8'hFF; ea[2] = 8'h00; ea[3] = 8'h01;
    clear_log();
    pulse_start();
    send(8'h04); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
`ifdef LOADER_CHECKSUM_EN
    send(8'h56);  // 11+22+33+44 = AA
`endif
    idle(3);
    total++; if (wa2.size() != 4) begin bad++; $display("FAIL wrap_nwrites got=%0d need=4", wa2.size()); end
    else for (int i = 0; i < 4; i++) begin
      total++; if (wa2[i] !== ea[i]) begin bad++; $display("FAIL wrap_addr%0d got=%02h need=%02h", i, wa2[i], ea[i]); end
    end
    total++; if (done2 !== 1'b1 || byte_count2 !== 9'd4) begin bad++; $display("FAIL wrap_done got=%0b/%0d need=1/4", done2, byte_count2); end
  endtask

  task automatic test_len0();
    clear_log();
    pulse_start();
    send(8'h00);
    for (int i = 0; i < 256; i++) send(8'(i));
`ifdef LOADER_CHECKSUM_EN
    send(8'h80);  // sum 0..255 = 0x7F80 -> 0x80
`endif
    idle(2);
    total++; if (byte_count !== 9'd256) begin bad++; $display("FAIL len0_count got=%0d need=256", byte_count); end
    total++; if (wa.size() != 256) begin bad++; $display("FAIL len0_nwrites got=%0d need=256", wa.size()); end
    else begin
      total++; if (wa[255] !== 8'hFF || wd[255] !== 8'hFF) begin bad++; $display("FAIL len0_last got=%02h:%02h need=ff:ff", wa[255], wd[255]); end
    end
    total++; if (wa2.size() != 256 || wa2[255] !== 8'hFD) begin bad++; $display("FAIL len0_last2 got n=%0d need n=256 last=fd", wa2.size()); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL len0_done got=%0b need=1", done); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_cksum_fail();
    clear_log();
    pulse_start();
    send(8'h02); send(8'h10); send(8'h20); send(8'h00);
    idle(2);
    total++; if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin bad++; $display("FAIL ck_err got err=%0b done=%0b hold=%0b need 1,0,1", error, done, cpu_hold); end
    total++; if (wa.size() != 2) begin bad++; $display("FAIL ck_nwrites got=%0d need=2", wa.size()); end
    pulse_start();
    total++; if (error !== 1'b0) begin bad++; $display("FAIL ck_clear got=%0b need=0", error); end
    send(8'h01); send(8'h55); send(8'hAB);
    idle(2);
    total++; if (done !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL ck_reload got done=%0b err=%0b need 1,0", done, error); end
  endtask
`endif

  task automatic test_start_ignored();
    clear_log();
    pulse_start();
    send(8'h03); send(8'h01);
    rx_valid = 1'b0;
    pulse_start();
    send(8'h02); send(8'h03);
`ifdef LOADER_CHECKSUM_EN
    send(8'hFA);
`endif
    idle(2);
    total++; if (byte_count !== 9'd3 || done !== 1'b1) begin bad++; $display("FAIL ign_count got=%0d/%0b need=3/1", byte_count, done); end
    total++; if (wa.size() != 3) begin bad++; $display("FAIL ign_nwrites got=%0d need=3", wa.size()); end
    else begin
      total++; if (wa[2] !== 8'h02 || wd[2] !== 8'h03) begin bad++; $display("FAIL ign_last got=%02h:%02h need=02:03", wa[2], wd[2]); end
    end
  endtask

  task automatic test_stall_abort();
    clear_log();
    pulse_start();
    send(8'h05); idle(1);
    send(8'h5A); idle(1);
    send(8'hA5); idle(1);
    total++; if (wa.size() != 2) begin bad++; $display("FAIL stall_nwrites got=%0d need=2", wa.size()); end
    else begin
      total++; if (wc[1] - wc[0] != 2) begin bad++; $display("FAIL stall_gap got=%0d need=2", wc[1] - wc[0]); end
      total++; if (wd[1] !== 8'hA5 || wa[1] !== 8'h01) begin bad++; $display("FAIL stall_data got=%02h:%02h need=01:a5", wa[1], wd[1]); end
    end
    total++; if (mem_write !== 1'b0 || byte_count !== 9'd2) begin bad++; $display("FAIL stall_hold got wr=%0b cnt=%0d need 0,2", mem_write, byte_count); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (cpu_hold !== 1'b1 || cpu_hold2 !== 1'b0) begin bad++; $display("FAIL abort_hold got=%0b/%0b need=1/0", cpu_hold, cpu_hold2); end
    total++; if (rx_ready !== 1'b0 || byte_count !== 9'd0) begin bad++; $display("FAIL abort_idle got rdy=%0b cnt=%0d need 0,0", rx_ready, byte_count); end
    rx_data = 8'h77; rx_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    total++; if (wa.size() != 2) begin bad++; $display("FAIL abort_nowrite got=%0d need=2", wa.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_len0();
`ifdef LOADER_CHECKSUM_EN
    test_cksum_fail();
`endif
    test_start_ignored();
    test_stall_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
